csr_fwd_pipe: RTL and testbench

Parametrised CSR write-tracking and forwarding unit for the CPU pipeline. It captures every CSR write leaving EX into an internal shift register of in-flight entries, one per post-EX stage (MEM ... WB). It forwards the youngest matching value back to an EX-stage CSR read. It holds EX when the matching entry is marked non-forwardable, and it issues the single architectural CSR-file write when the entry reaches WB.

---
 rtl/csr_fwd_pipe_if.sv | 48 ++++
 rtl/csr_fwd_pipe.sv | 98 +++++++++
 tb/tb_csr_fwd_pipe.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_fwd_pipe_if.sv
// rtl/csr_fwd_pipe_if.sv - EX-side CSR write/read bus, forwarding and writeback signals
//
// Purpose: bundles every non-clock/reset signal of csr_fwd_pipe.
// Ports (master drives / slave receives):
//   stall, flush                  pipeline control
//   ex_valid, ex_csr_we/nofwd/waddr/wdata, ex_csr_re/raddr   EX-stage CSR access
//   fwd_sel, fwd_data, csr_hazard                            forwarding result to EX
//   wb_csr_we/waddr/wdata                                    CSR-file write
//   hazard_cnt                                               saturating hazard-cycle count
interface csr_fwd_pipe_if #(
  parameter int STAGES = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = $clog2(STAGES + 1);

  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic              ex_csr_we;
  logic              ex_csr_nofwd;
  logic [ADDR_W-1:0] ex_csr_waddr;
  logic [DATA_W-1:0] ex_csr_wdata;
  logic              ex_csr_re;
  logic [ADDR_W-1:0] ex_csr_raddr;
  logic [SEL_W-1:0]  fwd_sel;
  logic [DATA_W-1:0] fwd_data;
  logic              csr_hazard;
  logic              wb_csr_we;
  logic [ADDR_W-1:0] wb_csr_waddr;
  logic [DATA_W-1:0] wb_csr_wdata;
  logic [CNT_W-1:0]  hazard_cnt;

  modport master (
    output stall, flush, ex_valid, ex_csr_we, ex_csr_nofwd, ex_csr_waddr,
           ex_csr_wdata, ex_csr_re, ex_csr_raddr,
    input  fwd_sel, fwd_data, csr_hazard, wb_csr_we, wb_csr_waddr,
           wb_csr_wdata, hazard_cnt
  );

  modport slave (
    input  stall, flush, ex_valid, ex_csr_we, ex_csr_nofwd, ex_csr_waddr,
           ex_csr_wdata, ex_csr_re, ex_csr_raddr,
    output fwd_sel, fwd_data, csr_hazard, wb_csr_we, wb_csr_waddr,
           wb_csr_wdata, hazard_cnt
  );
endinterface

// File: rtl/csr_fwd_pipe.sv
// rtl/csr_fwd_pipe.sv - CSR write tracking, EX forwarding and single CSR-file writeback
//
// Purpose: shifts every CSR write leaving EX through STAGES in-flight entries
// (entry 1 = MEM ... entry STAGES = WB), forwards the youngest matching value to
// an EX CSR read, holds EX on a non-forwardable match and writes the CSR file
// once when the entry reaches WB.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    csr_fwd_pipe_if slave: EX access in, forward/hazard/writeback/count out
module csr_fwd_pipe #(
  parameter int STAGES = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  csr_fwd_pipe_if.slave bus
);
  localparam int SEL_W = $clog2(STAGES + 1);

  logic [STAGES:1]   v_q;
  logic [STAGES:1]   nofwd_q;
  logic [ADDR_W-1:0] addr_q [1:STAGES];
  logic [DATA_W-1:0] data_q [1:STAGES];
  logic [CNT_W-1:0]  cnt_q;

  logic              rd;
  logic              hit;
  logic              hit_nofwd;
  logic [SEL_W-1:0]  hit_sel;
  logic [DATA_W-1:0] hit_data;
  logic              hazard;
  logic              cap_v;

  // Scan oldest to youngest so the lowest matching k is the one left standing.
  // Only registered entries are compared, so an instruction never matches its
  // own write and csr_hazard has no path from the capture logic.
  always_comb begin
    hit       = 1'b0;
    hit_nofwd = 1'b0;
    hit_sel   = '0;
    hit_data  = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (v_q[k] && (addr_q[k] == bus.ex_csr_raddr)) begin
        hit       = 1'b1;
        hit_nofwd = nofwd_q[k];
        hit_sel   = SEL_W'(k);
        hit_data  = data_q[k];
      end
    end
  end

  assign rd     = bus.ex_valid & bus.ex_csr_re;
  assign hazard = rd & hit & hit_nofwd;
  // A hazard blocks capture, which pushes a bubble into entry 1 while the
  // older entries drain; the blocking entry retires and the hazard self-clears.
  assign cap_v  = bus.ex_valid & bus.ex_csr_we & ~bus.flush & ~hazard;

  assign bus.csr_hazard   = hazard;
  assign bus.fwd_sel      = (rd & hit & ~hit_nofwd) ? hit_sel  : '0;
  assign bus.fwd_data     = (rd & hit & ~hit_nofwd) ? hit_data : '0;
  assign bus.wb_csr_we    = v_q[STAGES] & ~bus.stall;
  assign bus.wb_csr_waddr = addr_q[STAGES];
  assign bus.wb_csr_wdata = data_q[STAGES];
  assign bus.hazard_cnt   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      nofwd_q <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else if (!bus.stall) begin
      v_q[1]     <= cap_v;
      nofwd_q[1] <= bus.ex_csr_nofwd;
      addr_q[1]  <= bus.ex_csr_waddr;
      data_q[1]  <= bus.ex_csr_wdata;
      for (int k = 2; k <= STAGES; k++) begin
        v_q[k]     <= v_q[k-1];
        nofwd_q[k] <= nofwd_q[k-1];
        addr_q[k]  <= addr_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (hazard && !bus.stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_csr_fwd_pipe.sv
// tb/tb_csr_fwd_pipe.sv - directed self-checking bench for csr_fwd_pipe
module tb_csr_fwd_pipe;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  csr_fwd_pipe_if #(.STAGES(2), .ADDR_W(12), .DATA_W(32), .CNT_W(16)) bus1 ();
  csr_fwd_pipe_if #(.STAGES(2), .ADDR_W(12), .DATA_W(32), .CNT_W(2))  bus2 ();

  csr_fwd_pipe #(.STAGES(2), .ADDR_W(12), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );
  csr_fwd_pipe #(.STAGES(2), .ADDR_W(12), .DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  assign bus2.stall        = bus1.stall;
  assign bus2.flush        = bus1.flush;
  assign bus2.ex_valid     = bus1.ex_valid;
  assign bus2.ex_csr_we    = bus1.ex_csr_we;
  assign bus2.ex_csr_nofwd = bus1.ex_csr_nofwd;
  assign bus2.ex_csr_waddr = bus1.ex_csr_waddr;
  assign bus2.ex_csr_wdata = bus1.ex_csr_wdata;
  assign bus2.ex_csr_re    = bus1.ex_csr_re;
  assign bus2.ex_csr_raddr = bus1.ex_csr_raddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus1.stall        = 1'b0;
    bus1.flush        = 1'b0;
    bus1.ex_valid     = 1'b0;
    bus1.ex_csr_we    = 1'b0;
    bus1.ex_csr_nofwd = 1'b0;
    bus1.ex_csr_waddr = '0;
    bus1.ex_csr_wdata = '0;
    bus1.ex_csr_re    = 1'b0;
    bus1.ex_csr_raddr = '0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic nf);
    bus1.ex_valid     = 1'b1;
    bus1.ex_csr_we    = 1'b1;
    bus1.ex_csr_nofwd = nf;
    bus1.ex_csr_waddr = a;
    bus1.ex_csr_wdata = d;
  endtask

  task automatic rd(input logic [11:0] a);
    bus1.ex_valid     = 1'b1;
    bus1.ex_csr_re    = 1'b1;
    bus1.ex_csr_raddr = a;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_sel", 64'(bus1.fwd_sel), 64'd0);
    chk("rst_fwd_data", 64'(bus1.fwd_data), 64'd0);
    chk("rst_hazard", 64'(bus1.csr_hazard), 64'd0);
    chk("rst_wb_we", 64'(bus1.wb_csr_we), 64'd0);
    chk("rst_cnt", 64'(bus1.hazard_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // basic forward from entry 1, then entry 2 with writeback
    wr(12'h300, 32'hA5, 1'b0);
    #2;
    tick();
    idle(); rd(12'h300);
    #2;
    chk("t1_sel_c1", 64'(bus1.fwd_sel), 64'd1);
    chk("t1_data_c1", 64'(bus1.fwd_data), 64'hA5);
    chk("t1_wb_we_c1", 64'(bus1.wb_csr_we), 64'd0);
    tick();
    #2;
    chk("t1_sel_c2", 64'(bus1.fwd_sel), 64'd2);
    chk("t1_data_c2", 64'(bus1.fwd_data), 64'hA5);
    chk("t1_wb_we_c2", 64'(bus1.wb_csr_we), 64'd1);
    chk("t1_wb_addr", 64'(bus1.wb_csr_waddr), 64'h300);
    chk("t1_wb_data", 64'(bus1.wb_csr_wdata), 64'hA5);
    tick();
    #2;
    chk("t1_sel_c3", 64'(bus1.fwd_sel), 64'd0);
    chk("t1_wb_we_c3", 64'(bus1.wb_csr_we), 64'd0);

    // youngest match wins
    idle(); wr(12'h305, 32'd1, 1'b0);
    tick();
    wr(12'h305, 32'd2, 1'b0);
    tick();
    idle(); rd(12'h305);
    #2;
    chk("t2_sel_young", 64'(bus1.fwd_sel), 64'd1);
    chk("t2_data_young", 64'(bus1.fwd_data), 64'd2);
    chk("t2_wb_data_old", 64'(bus1.wb_csr_wdata), 64'd1);
    tick();
    #2;
    chk("t2_sel_next", 64'(bus1.fwd_sel), 64'd2);
    chk("t2_data_next", 64'(bus1.fwd_data), 64'd2);
    tick();

    // nofwd hazard, with flush in the first hazard cycle
    idle(); wr(12'h341, 32'h77, 1'b1);
    tick();
    idle(); rd(12'h341); wr(12'h342, 32'h99, 1'b0);
    bus1.flush = 1'b1;
    #2;
    chk("t3_haz_c1", 64'(bus1.csr_hazard), 64'd1);
    chk("t3_sel_c1", 64'(bus1.fwd_sel), 64'd0);
    chk("t3_data_c1", 64'(bus1.fwd_data), 64'd0);
    tick();
    bus1.flush = 1'b0;
    #2;
    chk("t3_haz_c2", 64'(bus1.csr_hazard), 64'd1);
    chk("t3_wb_we", 64'(bus1.wb_csr_we), 64'd1);
    chk("t3_wb_addr", 64'(bus1.wb_csr_waddr), 64'h341);
    tick();
    idle(); rd(12'h342);
    #2;
    chk("t3_haz_clear", 64'(bus1.csr_hazard), 64'd0);
    chk("t3_bubble_sel", 64'(bus1.fwd_sel), 64'd0);
    chk("t3_cnt", 64'(bus1.hazard_cnt), 64'd2);
    chk("t3_cnt_sat", 64'(bus2.hazard_cnt), 64'd2);
    tick();

    // stall holding an entry at WB
    idle(); wr(12'h310, 32'h1234, 1'b0);
    tick();
    idle();
    #2;
    chk("t4_wb_we_pre", 64'(bus1.wb_csr_we), 64'd0);
    tick();
    bus1.stall = 1'b1; rd(12'h310);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t4_wb_we_stall", 64'(bus1.wb_csr_we), 64'd0);
      chk("t4_sel_stall", 64'(bus1.fwd_sel), 64'd2);
      chk("t4_data_stall", 64'(bus1.fwd_data), 64'h1234);
      tick();
    end
    bus1.stall = 1'b0;
    #2;
    chk("t4_wb_we_rel", 64'(bus1.wb_csr_we), 64'd1);
    chk("t4_sel_rel", 64'(bus1.fwd_sel), 64'd2);
    tick();
    #2;
    chk("t4_wb_we_after", 64'(bus1.wb_csr_we), 64'd0);
    chk("t4_sel_after", 64'(bus1.fwd_sel), 64'd0);
    tick();

    // flush kills the capture
    idle(); wr(12'h320, 32'h55, 1'b0);
    bus1.flush = 1'b1;
    tick();
    idle(); rd(12'h320);
    #2;
    chk("t5_flush_sel", 64'(bus1.fwd_sel), 64'd0);
    chk("t5_flush_wb1", 64'(bus1.wb_csr_we), 64'd0);
    tick();
    #2;
    chk("t5_flush_wb2", 64'(bus1.wb_csr_we), 64'd0);
    tick();

    // asynchronous reset with two pending entries
    idle(); wr(12'h330, 32'd5, 1'b0);
    tick();
    wr(12'h331, 32'd6, 1'b0);
    tick();
    idle(); rd(12'h331);
    #2;
    chk("t5_pre_rst_sel", 64'(bus1.fwd_sel), 64'd1);
    chk("t5_pre_rst_wb", 64'(bus1.wb_csr_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_sel", 64'(bus1.fwd_sel), 64'd0);
    chk("t5_rst_data", 64'(bus1.fwd_data), 64'd0);
    chk("t5_rst_wb", 64'(bus1.wb_csr_we), 64'd0);
    chk("t5_rst_cnt", 64'(bus1.hazard_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    idle();
    #2;
    chk("t5_post_wb1", 64'(bus1.wb_csr_we), 64'd0);
    tick();
    #2;
    chk("t5_post_wb2", 64'(bus1.wb_csr_we), 64'd0);
    tick();

    // repeating nofwd write+read: W,H,H,W,H,H,... drives counter saturation
    idle(); wr(12'h341, 32'h1, 1'b1); rd(12'h341);
    #2;
    chk("t6_haz_c0", 64'(bus1.csr_hazard), 64'd0);
    tick(); tick(); tick();
    #2;
    chk("t6_cnt_c3", 64'(bus1.hazard_cnt), 64'd2);
    chk("t6_cnt_sat_c3", 64'(bus2.hazard_cnt), 64'd2);
    tick(); tick(); tick();
    #2;
    chk("t6_cnt_c6", 64'(bus1.hazard_cnt), 64'd4);
    chk("t6_cnt_sat_c6", 64'(bus2.hazard_cnt), 64'd3);
    tick(); tick(); tick();
    #2;
    chk("t6_cnt_c9", 64'(bus1.hazard_cnt), 64'd6);
    chk("t6_cnt_sat_c9", 64'(bus2.hazard_cnt), 64'd3);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
